// File: rtl/digi_ota_pkg.sv
// digi_ota_pkg: shared constants and types for the digital OTA offset-trim
// calibration controller (digi_ota_trim_ctrl).
// Optional feature macro used by the top: DIGI_OTA_TRIM_MAJORITY_EN.
package digi_ota_pkg;

    // Default build-time configuration.
    localparam int DEFAULT_TRIM_W     = 6;
    localparam int DEFAULT_SETTLE_CYC = 8;
    localparam int DEFAULT_NSAMP      = 3;

    // Calibration FSM state encoding.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SETTLE = SETTLE,
        ST_SAMPLE = SAMPLE,
        ST_DONE   = DONE
    } state_e;

    // Midscale trim code (only the MSB set) for a code of width w.
    function automatic int midscale(input int w);
        return 1 << (w - 1);
    endfunction

    // Midscale for the default trim width.
    localparam int DEFAULT_MIDSCALE = 1 << (DEFAULT_TRIM_W - 1);

endpackage

// File: rtl/digi_ota_sync2.sv
// digi_ota_sync2: two-flop synchroniser for the asynchronous OTA comparator
// output. Synchronous active-high reset clears both stages to 0.
module digi_ota_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back capture stages; the first may go metastable.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so both stages
        // sample their inputs from before the edge and form a real 2-deep chain.
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/digi_ota_trim_ctrl.sv
// digi_ota_trim_ctrl: successive-approximation offset calibration of the
// digital OTA. Shorts the OTA inputs, binary-searches the offset-trim code
// MSB first, and holds the final code until the next calibration.
// Optional feature macro: DIGI_OTA_TRIM_MAJORITY_EN (NSAMP-sample majority
// vote per bit instead of a single sample).
module digi_ota_trim_ctrl
    import digi_ota_pkg::*;
#(
    parameter int TRIM_W     = DEFAULT_TRIM_W,
    parameter int SETTLE_CYC = DEFAULT_SETTLE_CYC,
    parameter int NSAMP      = DEFAULT_NSAMP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cmp_in,
    output logic [TRIM_W-1:0] trim_code,
    output logic              ota_en,
    output logic              cal_mode,
    output logic              busy,
    output logic              done,
    output logic              cal_fail
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int IDX_W = $clog2(TRIM_W);
    localparam logic [TRIM_W-1:0] MID = TRIM_W'(midscale(TRIM_W));

    // Reject configurations the datapath cannot support.
    if (SETTLE_CYC < 3) begin : g_chk_settle
        $error("SETTLE_CYC must be >= 3 to cover the synchroniser latency");
    end
    if (TRIM_W < 2) begin : g_chk_trim_w
        $error("TRIM_W must be >= 2");
    end
    if ((NSAMP < 1) || ((NSAMP % 2) == 0)) begin : g_chk_nsamp
        $error("NSAMP must be odd and >= 1");
    end

    // Synchronised comparator; every decision uses this, never cmp_in.
    logic cmp_s;

    digi_ota_sync2 u_sync_cmp (
        .clk (clk),
        .rst (rst),
        .d_i (cmp_in),
        .q_o (cmp_s)
    );

    state_e            state_q,  state_d;
    logic [TRIM_W-1:0] trim_q,   trim_d;
    logic [TRIM_W-1:0] saved_q,  saved_d;
    logic              ota_en_q, ota_en_d;
    logic              en_sv_q,  en_sv_d;
    logic              fail_q,   fail_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    logic              clear_bit;
    logic              sample_last;
    logic [TRIM_W-1:0] code_upd;

`ifdef DIGI_OTA_TRIM_MAJORITY_EN
    localparam int SAMP_W = $clog2(NSAMP + 1);

    logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [SAMP_W-1:0] ones_q,     ones_d;
    logic [SAMP_W-1:0] ones_sum;

    // Majority-vote sample counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt_q <= '0;
            ones_q     <= '0;
        end else begin
            samp_cnt_q <= samp_cnt_d;
            ones_q     <= ones_d;
        end
    end
`endif

    // Controller state register.
    always_ff @(posedge clk) begin
        // NOTE: the saved code resets to midscale too, so an abort straight
        // after reset restores a defined code rather than an X.
        if (rst) begin
            state_q  <= ST_IDLE;
            trim_q   <= MID;
            saved_q  <= MID;
            ota_en_q <= 1'b0;
            en_sv_q  <= 1'b0;
            fail_q   <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            trim_q   <= trim_d;
            saved_q  <= saved_d;
            ota_en_q <= ota_en_d;
            en_sv_q  <= en_sv_d;
            fail_q   <= fail_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: search sequencing, bit decision, abort handling.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        trim_d   = trim_q;
        saved_d  = saved_q;
        ota_en_d = ota_en_q;
        en_sv_d  = en_sv_q;
        fail_d   = fail_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;

`ifdef DIGI_OTA_TRIM_MAJORITY_EN
        samp_cnt_d  = samp_cnt_q;
        ones_d      = ones_q;
        ones_sum    = ones_q + SAMP_W'(cmp_s);
        sample_last = (samp_cnt_q == SAMP_W'(NSAMP - 1));
        clear_bit   = (ones_sum > SAMP_W'(NSAMP / 2));
`else
        sample_last = 1'b1;
        clear_bit   = cmp_s;
`endif

        // Code after deciding the current bit and trialling the next lower one.
        code_upd = trim_q;
        if (clear_bit) begin
            code_upd[idx_q] = 1'b0;
        end
        if (idx_q != '0) begin
            code_upd[idx_q - IDX_W'(1)] = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    saved_d  = trim_q;
                    en_sv_d  = ota_en_q;
                    idx_d    = IDX_W'(TRIM_W - 1);
                    trim_d   = MID;
                    ota_en_d = 1'b1;
                    fail_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
`ifdef DIGI_OTA_TRIM_MAJORITY_EN
                samp_cnt_d = '0;
                ones_d     = '0;
`endif
                if (abort) begin
                    trim_d   = saved_q;
                    ota_en_d = en_sv_q;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                if (abort) begin
                    trim_d   = saved_q;
                    ota_en_d = en_sv_q;
                    state_d  = ST_IDLE;
                end else if (!sample_last) begin
`ifdef DIGI_OTA_TRIM_MAJORITY_EN
                    samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                    ones_d     = ones_sum;
`endif
                end else begin
                    trim_d = code_upd;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = ST_SETTLE;
                    end else begin
                        // Final code on either rail means the trim range ran out.
                        fail_d  = (&code_upd) | ~(|code_upd);
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign trim_code = trim_q;
    assign ota_en    = ota_en_q;
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign cal_mode  = busy;
    assign done      = (state_q == ST_DONE);
    assign cal_fail  = fail_q;

endmodule

// File: tb/tb_digi_ota_trim_ctrl.sv
// tb_digi_ota_trim_ctrl: scoreboard bench for digi_ota_trim_ctrl. The
// comparator is modelled as cmp = (trim_code > target), optionally inverted
// on chosen cycles. Honours DIGI_OTA_TRIM_MAJORITY_EN when defined.
module tb_digi_ota_trim_ctrl;

    localparam int TRIM_W     = 6;
    localparam int SETTLE_CYC = 8;
    localparam int NSAMP      = 3;
`ifdef DIGI_OTA_TRIM_MAJORITY_EN
    localparam int SAMP_CYC = NSAMP;
    localparam bit MAJ      = 1'b1;
`else
    localparam int SAMP_CYC = 1;
    localparam bit MAJ      = 1'b0;
`endif
    localparam int PERIOD = SETTLE_CYC + SAMP_CYC;
    localparam int LAT    = TRIM_W * PERIOD;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              cmp_in;
    logic [TRIM_W-1:0] trim_code;
    logic              ota_en;
    logic              cal_mode;
    logic              busy;
    logic              done;
    logic              cal_fail;

    int   target;
    logic flip;
    int   cyc = 0;

    typedef struct {
        int trim;
        int fail;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   seq37[6] = '{32, 48, 40, 36, 38, 37};

    digi_ota_trim_ctrl #(
        .TRIM_W     (TRIM_W),
        .SETTLE_CYC (SETTLE_CYC),
        .NSAMP      (NSAMP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cmp_in    (cmp_in),
        .trim_code (trim_code),
        .ota_en    (ota_en),
        .cal_mode  (cal_mode),
        .busy      (busy),
        .done      (done),
        .cal_fail  (cal_fail)
    );

    // Comparator model: high when the trim code is above the target offset.
    assign cmp_in = (int'(trim_code) > target) ^ flip;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the falling edge of cycle c.
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Present start for one edge; s returns the cycle number of the accepting edge.
    task automatic pulse_start(input int tgt, output int s);
        @(negedge clk);
        target = tgt;
        start  = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic start_cal(input int tgt, input int exp_trim, input int exp_fail,
                             output int s);
        exp_t e;
        pulse_start(tgt, s);
        e.trim     = exp_trim;
        e.fail     = exp_fail;
        e.done_cyc = s + LAT;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < LAT + 50 && sb.size() != 0; i++) @(negedge clk);
        check("done_timeout", sb.size(), 0);
    endtask

    // Monitor: every done pulse is compared against the oldest expectation.
    initial begin : monitor
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    e = sb.pop_front();
                    check("result_code", int'(trim_code), e.trim);
                    check("result_cal_fail", int'(cal_fail), e.fail);
                    check("done_cycle", cyc, e.done_cyc);
                    check("busy_cycles", run, LAT);
                    check("busy_at_done", int'(busy), 0);
                    check("cal_mode_at_done", int'(cal_mode), 0);
                    check("ota_en_at_done", int'(ota_en), 1);
                end
                run = 0;
            end else if (busy) begin
                run++;
            end else begin
                run = 0;
            end
        end
    end

    initial begin : stimulus
        int   s;
        exp_t e;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        flip   = 1'b0;
        target = 0;
        repeat (3) @(negedge clk);
        check("reset_trim", int'(trim_code), 32);
        check("reset_busy", int'(busy), 0);
        check("reset_ota_en", int'(ota_en), 0);
        check("reset_cal_mode", int'(cal_mode), 0);
        check("reset_done", int'(done), 0);
        check("reset_cal_fail", int'(cal_fail), 0);
        rst = 1'b0;

        // Reset while settling bit 3.
        pulse_start(37, s);
        wait_until(s + 2 * PERIOD + 3);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_trim", int'(trim_code), 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_trim", int'(trim_code), 32);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_ota_en", int'(ota_en), 0);
        check("rst_mid_cal_mode", int'(cal_mode), 0);

        // Target 37 with per-bit code trace.
        start_cal(37, 37, 0, s);
        for (int k = 0; k < TRIM_W; k++) begin
            wait_until(s + k * PERIOD + 4);
            check("trim_seq", int'(trim_code), seq37[k]);
        end
        wait_done();

        // Rails, then recovery.
        start_cal(0, 0, 1, s);
        wait_done();
        start_cal(63, 63, 1, s);
        wait_done();
        @(negedge clk);
        check("cal_fail_sticky", int'(cal_fail), 1);
        start_cal(20, 20, 0, s);
        check("cal_fail_cleared_on_start", int'(cal_fail), 0);
        wait_done();

        // Abort in the third SAMPLE with start held high throughout.
        start_cal(37, 37, 0, s);
        wait_done();
        @(negedge clk);
        target = 10;
        start  = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        wait_until(s + PERIOD + 4);
        check("abort_run_trim_bit4", int'(trim_code), 16);
        wait_until(s + 2 * PERIOD + SETTLE_CYC);
        check("abort_run_busy", int'(busy), 1);
        check("abort_run_trim_bit3", int'(trim_code), 8);
        abort = 1'b1;
        start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check("abort_trim_restored", int'(trim_code), 37);
        check("abort_busy", int'(busy), 0);
        check("abort_cal_mode", int'(cal_mode), 0);
        check("abort_done", int'(done), 0);
        check("abort_ota_en", int'(ota_en), 1);
        repeat (LAT + 10) @(negedge clk);
        check("abort_trim_held", int'(trim_code), 37);

        // Abort in IDLE does nothing.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_trim", int'(trim_code), 37);
        check("idle_abort_busy", int'(busy), 0);

        // Start and abort together in IDLE; one corrupted sample per bit.
        @(negedge clk);
        target = 37;
        start  = 1'b1;
        abort  = 1'b1;
        @(posedge clk);
        #1;
        s          = cyc;
        e.trim     = MAJ ? 37 : 0;
        e.fail     = MAJ ? 0 : 1;
        e.done_cyc = s + LAT;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_beats_abort", int'(busy), 1);
        while (sb.size() != 0 && cyc < s + LAT + 20) begin
            flip = (((cyc - s) % PERIOD) == SETTLE_CYC - 2) && ((cyc - s) < LAT);
            @(negedge clk);
        end
        flip = 1'b0;
        check("flip_done_timeout", sb.size(), 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
